// File: rtl/demoscene_pkg.sv
// demoscene_pkg: shared audio constants, note tables and helpers
// MIDSCALE, NOTE_REST, NOTE_NOISE, INC_TABLE (octave-0 phase increments), SEQ_ROM (16-step loop).
// AUDIO_NOISE_EN: when defined, NOTE_NOISE plays LFSR noise; otherwise it is treated as a rest.
package demoscene_pkg;
  localparam logic [7:0] MIDSCALE = 8'h80;
  localparam logic [5:0] NOTE_REST = 6'd0;
  localparam logic [5:0] NOTE_NOISE = 6'd63;
  // C2..B2 at ~24.6 kHz sample rate with a 16-bit accumulator
  localparam logic [15:0] INC_TABLE [12] = '{
    16'd174, 16'd185, 16'd196, 16'd207, 16'd220, 16'd233,
    16'd247, 16'd261, 16'd277, 16'd293, 16'd311, 16'd330
  };
  localparam logic [5:0] SEQ_ROM [16] = '{
    6'd12, 6'd0, 6'd63, 6'd24, 6'd60, 6'd0, 6'd55, 6'd48,
    6'd36, 6'd0, 6'd62, 6'd63, 6'd7, 6'd19, 6'd50, 6'd0
  };
  function automatic logic [31:0] note_inc(input logic [5:0] n);
    logic [3:0] s;
    s = 4'(n % 12);
    return {16'd0, INC_TABLE[s]} << (n / 12);
  endfunction
  function automatic logic is_rest(input logic [5:0] n);
`ifdef AUDIO_NOISE_EN
    return n == NOTE_REST;
`else
    return n == NOTE_REST || n == NOTE_NOISE;
`endif
  endfunction
endpackage

// File: rtl/audio_envelope.sv
// audio_envelope: per-note amplitude envelope with load, decay and zero saturation
// clk, rst_n     : clock, asynchronous active-low reset
// tick_i         : sample tick; all state changes only on ticks
// load_i, rest_i : note load this tick; loaded note is a rest (env starts at 0)
// env_o          : current envelope amplitude
module audio_envelope #(
  parameter int ENV_DIV = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_i,
  input  logic       load_i,
  input  logic       rest_i,
  output logic [7:0] env_o
);
  localparam int CW = ENV_DIV > 1 ? $clog2(ENV_DIV) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] env_q, env_d;
  logic term;
  always_comb begin
    term = cnt_q == CW'(ENV_DIV - 1);
    cnt_d = !tick_i ? cnt_q : (load_i || term) ? '0 : cnt_q + 1'b1;
    // a load on the same tick wins over the decrement
    env_d = !tick_i ? env_q :
            load_i ? (rest_i ? 8'd0 : 8'hFF) :
            (term && env_q != 8'd0) ? env_q - 1'b1 : env_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      env_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      env_q <= env_d;
    end
  end
  assign env_o = env_q;
endmodule

// File: rtl/audio_sequencer.sv
// audio_sequencer: 16-step note sequencer and square-wave voice feeding the pwm sample input
// clk, rst_n     : pixel clock, asynchronous active-low reset
// enable, mute   : run/freeze all counters; force midscale output while sequencing continues
// sample         : unsigned 8-bit sample, midscale 8'h80; sample_strobe pulses once per update
// step_idx       : current step 0..15; note_on: envelope nonzero and note is not a rest
// AUDIO_NOISE_EN : when defined, a 16-bit LFSR voices NOTE_NOISE steps
module audio_sequencer
  import demoscene_pkg::*;
#(
  parameter int SAMPLE_DIV   = 1024,
  parameter int STEP_SAMPLES = 3072,
  parameter int ENV_DIV      = 16,
  parameter int PHASE_W      = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       mute,
  output logic [7:0] sample,
  output logic       sample_strobe,
  output logic [3:0] step_idx,
  output logic       note_on
);
  localparam int DW = SAMPLE_DIV > 1 ? $clog2(SAMPLE_DIV) : 1;
  localparam int SW = STEP_SAMPLES > 1 ? $clog2(STEP_SAMPLES) : 1;
  logic [DW-1:0] div_q, div_d;
  logic [SW-1:0] samp_q, samp_d;
  logic [3:0] step_q, step_d;
  logic [5:0] note_q, note_d, rom_note;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [7:0] sample_q, sample_d, env, amp;
  logic strobe_q, tick, load, samp_end, up, silent;
`ifdef AUDIO_NOISE_EN
  logic [15:0] lfsr_q, lfsr_d;
`endif
  audio_envelope #(.ENV_DIV(ENV_DIV)) u_env (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick_i (tick),
    .load_i (load),
    .rest_i (is_rest(rom_note)),
    .env_o  (env)
  );
  always_comb begin
    tick = enable && div_q == DW'(SAMPLE_DIV - 1);
    load = tick && samp_q == '0;
    samp_end = samp_q == SW'(STEP_SAMPLES - 1);
    rom_note = SEQ_ROM[step_q];
    div_d = !enable ? div_q : tick ? '0 : div_q + 1'b1;
    samp_d = !tick ? samp_q : samp_end ? '0 : samp_q + 1'b1;
    step_d = (tick && samp_end) ? step_q + 1'b1 : step_q;
    note_d = load ? rom_note : note_q;
    phase_d = load ? '0 : tick ? phase_q + PHASE_W'(note_inc(note_q)) : phase_q;
    amp = {1'b0, env[7:1]};
`ifdef AUDIO_NOISE_EN
    lfsr_d = tick ? {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]} : lfsr_q;
    up = note_q == NOTE_NOISE ? lfsr_q[0] : !phase_q[PHASE_W-1];
`else
    up = !phase_q[PHASE_W-1];
`endif
    silent = mute || env == 8'd0 || is_rest(note_q);
    // output reflects the state before this tick's updates
    sample_d = !tick ? sample_q : silent ? MIDSCALE : up ? MIDSCALE + amp : MIDSCALE - amp;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      samp_q <= '0;
      step_q <= '0;
      note_q <= NOTE_REST;
      phase_q <= '0;
      sample_q <= MIDSCALE;
      strobe_q <= 1'b0;
`ifdef AUDIO_NOISE_EN
      lfsr_q <= 16'hACE1;
`endif
    end else begin
      div_q <= div_d;
      samp_q <= samp_d;
      step_q <= step_d;
      note_q <= note_d;
      phase_q <= phase_d;
      sample_q <= sample_d;
      strobe_q <= tick;
`ifdef AUDIO_NOISE_EN
      lfsr_q <= lfsr_d;
`endif
    end
  end
  assign sample = sample_q;
  assign sample_strobe = strobe_q;
  assign step_idx = step_q;
  assign note_on = env != 8'd0 && !is_rest(note_q);
endmodule
